// File: rtl/ssp_tx_fifo_if.sv
// SSP transmit FIFO bus: APB write side, shifter pop side and status.
// The host/shifter side uses master; the FIFO uses slave.
interface ssp_tx_fifo_if #(
   parameter int AW = 2
);
   logic          psel;
   logic          pwrite;
   logic [7:0]    pwdata;
   logic          tx_pop;
   logic [7:0]    txdata;
   logic          tx_valid;
   logic          ssptxintr;
   logic [AW:0]   tx_count;
   logic          tx_ovf;

   modport master (
      output psel,
      output pwrite,
      output pwdata,
      output tx_pop,
      input  txdata,
      input  tx_valid,
      input  ssptxintr,
      input  tx_count,
      input  tx_ovf
   );

   modport slave (
      input  psel,
      input  pwrite,
      input  pwdata,
      input  tx_pop,
      output txdata,
      output tx_valid,
      output ssptxintr,
      output tx_count,
      output tx_ovf
   );
endinterface

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: buffers APB-written bytes for the serial shifter.
// Status outputs are decoded from registered occupancy.
module ssp_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          pclk,
   input  logic          clear_b,
   ssp_tx_fifo_if.slave  bus
);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   logic [7:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          ovf;
   logic          full;
   logic          empty;
   logic          wr_req;
   logic          push;
   logic          pop;

   assign full   = (count == FULL);
   assign empty  = (count == '0);
   assign wr_req = bus.psel & bus.pwrite;
   // Gating uses registered count, so a full FIFO never writes through.
   assign push   = wr_req & ~full;
   assign pop    = bus.tx_pop & ~empty;

   always_ff @(posedge pclk) begin
      if (push) begin
         mem[wr_ptr] <= bus.pwdata;
      end
   end

   always_ff @(posedge pclk or negedge clear_b) begin
      if (!clear_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
         if (wr_req && full) begin
            ovf <= 1'b1;
         end
      end
   end

   assign bus.txdata    = empty ? 8'h00 : mem[rd_ptr];
   assign bus.tx_valid  = ~empty;
   assign bus.ssptxintr = full;
   assign bus.tx_count  = count;
   assign bus.tx_ovf    = ovf;
endmodule

// File: doc/ssp_tx_fifo.md
Name: ssp_tx_fifo

Overview:
Transmit-side FIFO of the SSP. It buffers bytes written by the APB host until the SSP transmit shifter pulls them. The APB slave decode sits upstream; the serial transmit logic sits downstream and consumes one byte per pop. ssptxintr tells the host that the FIFO has no free entry.

Parameters:
DEPTH, 4, number of 8-bit entries; power of two, 2..16
AW, 2, pointer width, log2(DEPTH)

Ports:
pclk  input  1  APB/SSP clock; all state changes on the rising edge
clear_b  input  1  asynchronous active-low reset
psel  input  1  APB select for the TX data register
pwrite  input  1  APB write strobe; a push is requested when psel=1 and pwrite=1
pwdata  input  8  byte to enqueue
tx_pop  input  1  transmit logic consumes the head entry this cycle
txdata  output  8  head entry; valid when tx_valid=1
tx_valid  output  1  FIFO not empty
ssptxintr  output  1  FIFO full; no room for a further write
tx_count  output  AW+1  number of occupied entries, 0..DEPTH
tx_ovf  output  1  sticky flag; a write was attempted while full

Behaviour:
- Reset (clear_b=0, asynchronous, no clock edge needed):
  - wr_ptr=0, rd_ptr=0, count=0
  - txdata=8'h00, tx_valid=0, ssptxintr=0, tx_count=0, tx_ovf=0
  - Storage contents are don't-care, but txdata must read 8'h00 while empty.
  - Reset asserted mid-operation discards every entry immediately. Operation resumes on the first rising edge after clear_b=1.
- Push condition: push = psel & pwrite & (count != DEPTH).
  - On push: mem[wr_ptr] <= pwdata, and wr_ptr increments modulo DEPTH.
  - psel & pwrite while count==DEPTH: data is dropped, no state change except tx_ovf <= 1.
  - tx_ovf is cleared only by reset.
- Pop condition: pop = tx_pop & (count != 0).
  - On pop: rd_ptr increments modulo DEPTH.
  - tx_pop while empty is ignored; no underflow and no pointer movement.
- Push and pop in the same cycle:
  - Both are legal when count is between 1 and DEPTH-1: count is unchanged and both pointers advance.
  - At count==0 only the push takes effect, because pop is gated by empty. Count becomes 1.
  - At count==DEPTH only the pop takes effect, because push is gated by full. Count becomes DEPTH-1 and the write data is dropped with tx_ovf <= 1.
  - Push gating uses registered count, not same-cycle pop (no write-through when full).
- Count update: count <= count + push - pop, in AW+1 bits, never exceeding DEPTH.
- Combinational outputs from registered state:
  - txdata = mem[rd_ptr] when count != 0, else 8'h00
  - tx_valid = (count != 0)
  - ssptxintr = (count == DEPTH)
  - tx_count = count
- Latency: a byte written at edge N is visible on txdata/tx_valid after edge N, so it can be popped at edge N+1.
- Ordering: strict FIFO order, including across pointer wrap-around.
- ssptxintr rises the cycle after the push that fills the FIFO. It falls the cycle after the first pop from full.
- No read path: psel & ~pwrite has no effect on this block.

Test Plan:
1. Reset check: clear_b=0 with no clock, then release -> txdata=00, tx_valid=0, ssptxintr=0, tx_count=0, tx_ovf=0.
2. Fill and drain: write A1, B2, C3, D4 (one per cycle) -> tx_count=4 and ssptxintr=1 after the 4th edge. Then pop 4 times -> txdata shows A1, B2, C3, D4 in order; tx_valid=0 and ssptxintr=0 at the end.
3. Overflow: with the FIFO full, write EE -> tx_ovf=1, tx_count stays 4, and draining yields A1..D4 with no EE. Push+pop while full with data FF -> count=3 and FF is dropped.
4. Wrap-around: write 10, 11, 12; pop 2; write 13, 14, 15 -> count=4, and drain order is 12, 13, 14, 15.
5. Simultaneous push/pop at count=2 (entries 20, 21), pushing 22 -> count stays 2 and txdata goes from 20 to 21. Pop+push at count=0 with data 30 -> count=1 and txdata=30. Pop while empty -> no change.
6. Reset mid-stream: after 3 writes, assert clear_b for a half cycle -> all outputs return to reset values immediately. A subsequent write of 5A makes txdata=5A and count=1.
